dispatch_credit_scheduler: RTL and testbench

- Sits between the decoder and the issue queues (INTEGER_QUEUE, MEMORY_QUEUE, FLOAT_QUEUE, GLOBAL_QUEUE).
- Buffers decoded micro-ops in a 2-entry in-order FIFO and steers each one to its target queue, selected by the decoder's queue_et field.
- Tracks free slots in each queue with credit counters, so a uop is only sent to a queue that can accept it.
- Blocking is in-order (head-of-line).

---
 rtl/dispatch_credit_scheduler.sv | 104 ++++++++++
 tb/tb_dispatch_credit_scheduler.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/dispatch_credit_scheduler.sv
// dispatch_credit_scheduler: 2-entry in-order uop FIFO that steers each uop to an issue queue with credit flow control.
// Define DISPATCH_PERF_CNT_EN to add stall/dispatch performance counters.
module dispatch_credit_scheduler #(
  parameter int NUM_QUEUES = 4,
  parameter int QUEUE_DEPTH = 8,
  parameter int UOP_W = 128,
  localparam int CREDIT_W = $clog2(QUEUE_DEPTH + 1)
) (
  input  logic                           clk_i,
  input  logic                           rstn_i,
  input  logic                           flush_i,
  input  logic                           dec_valid_i,
  output logic                           dec_ready_o,
  input  logic [2:0]                     dec_queue_i,
  input  logic [UOP_W-1:0]               dec_uop_i,
  output logic [NUM_QUEUES-1:0]          q_valid_o,
  output logic [UOP_W-1:0]               q_uop_o,
  input  logic [NUM_QUEUES-1:0]          q_credit_ret_i,
  output logic [NUM_QUEUES*CREDIT_W-1:0] credits_o,
  output logic                           illegal_o,
  output logic                           credit_err_o,
  output logic                           busy_o
`ifdef DISPATCH_PERF_CNT_EN
  ,
  output logic [31:0]                    perf_stall_o,
  output logic [31:0]                    perf_disp_o
`endif
);
  localparam logic [3:0] NQ = 4'(NUM_QUEUES);
  localparam logic [CREDIT_W-1:0] FULL = CREDIT_W'(QUEUE_DEPTH);
  logic [1:0] cnt;
  logic [2:0] eq [2];
  logic [UOP_W-1:0] eu [2];
  logic [CREDIT_W-1:0] credit [NUM_QUEUES];
  logic [NUM_QUEUES-1:0] sat;
  logic illegal_q, err_q, accept, legal, push, pop;
  logic [1:0] wp;
  assign dec_ready_o = rstn_i & (cnt != 2'd2) & ~flush_i;
  assign accept = dec_valid_i & dec_ready_o;
  assign legal = {1'b0, dec_queue_i} < NQ;
  assign push = accept & legal;
  assign pop = |q_valid_o;
  assign wp = cnt - {1'b0, pop};
  assign q_uop_o = eu[0];
  assign busy_o = cnt != 2'd0;
  assign illegal_o = illegal_q;
  assign credit_err_o = err_q;
  // Strobe is combinational from the head and its credit; only the head can ever fire.
  for (genvar g = 0; g < NUM_QUEUES; g++) begin : g_q
    assign q_valid_o[g] = busy_o & ~flush_i & (eq[0] == 3'(g)) & (credit[g] != '0);
    assign sat[g] = q_credit_ret_i[g] & ~q_valid_o[g] & (credit[g] == FULL);
    assign credits_o[g*CREDIT_W +: CREDIT_W] = credit[g];
  end
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt <= 2'd0;
      eq[0] <= 3'd0;
      eq[1] <= 3'd0;
      eu[0] <= '0;
      eu[1] <= '0;
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= accept & ~legal;
      cnt <= flush_i ? 2'd0 : cnt + {1'b0, push} - {1'b0, pop};
      if (pop) begin
        eq[0] <= eq[1];
        eu[0] <= eu[1];
      end
      if (push && wp == 2'd0) begin
        eq[0] <= dec_queue_i;
        eu[0] <= dec_uop_i;
      end
      if (push && wp == 2'd1) begin
        eq[1] <= dec_queue_i;
        eu[1] <= dec_uop_i;
      end
    end
  end
  // Simultaneous dispatch and return cancel; a return at full saturates and flags the error.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < NUM_QUEUES; i++) credit[i] <= FULL;
      err_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_QUEUES; i++)
        if (q_credit_ret_i[i] & ~q_valid_o[i])
          credit[i] <= (credit[i] == FULL) ? FULL : credit[i] + CREDIT_W'(1);
        else if (q_valid_o[i] & ~q_credit_ret_i[i])
          credit[i] <= credit[i] - CREDIT_W'(1);
      err_q <= err_q | (|sat);
    end
  end
`ifdef DISPATCH_PERF_CNT_EN
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      perf_stall_o <= '0;
      perf_disp_o <= '0;
    end else begin
      if (busy_o & ~flush_i & ~pop) perf_stall_o <= perf_stall_o + 32'd1;
      if (pop) perf_disp_o <= perf_disp_o + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_dispatch_credit_scheduler.sv
// tb_dispatch_credit_scheduler: directed vector table plus hand-written multi-cycle sequences.
module tb_dispatch_credit_scheduler;
  logic clk = 1'b0, rstn_i, flush_i, dec_valid_i, dec_ready_o, illegal_o, credit_err_o, busy_o;
  logic [2:0] dec_queue_i;
  logic [127:0] dec_uop_i, q_uop_o;
  logic [3:0] q_valid_o, q_credit_ret_i;
  logic [15:0] credits_o;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  dispatch_credit_scheduler dut (
    .clk_i(clk), .rstn_i(rstn_i), .flush_i(flush_i), .dec_valid_i(dec_valid_i),
    .dec_ready_o(dec_ready_o), .dec_queue_i(dec_queue_i), .dec_uop_i(dec_uop_i),
    .q_valid_o(q_valid_o), .q_uop_o(q_uop_o), .q_credit_ret_i(q_credit_ret_i),
    .credits_o(credits_o), .illegal_o(illegal_o), .credit_err_o(credit_err_o), .busy_o(busy_o)
  );
  typedef struct packed {
    logic fl, v;
    logic [2:0] q;
    logic [7:0] tag;
    logic [3:0] ret;
    logic rdy;
    logic [3:0] qv;
    logic [7:0] tg;
    logic ill, busy, err;
    logic [15:0] cr;
  } row_t;
  row_t rows [64];
  int n = 0;
  task automatic add(input logic fl, v, input logic [2:0] q, input logic [7:0] tag, input logic [3:0] ret,
                     input logic rdy, input logic [3:0] qv, input logic [7:0] tg,
                     input logic ill, busy, err, input logic [15:0] cr);
    rows[n] = '{fl, v, q, tag, ret, rdy, qv, tg, ill, busy, err, cr};
    n++;
  endtask
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_out(input string nm, input logic rdy, input logic [3:0] qv, input logic [7:0] tg,
                         input logic ill, busy, err, input logic [15:0] cr);
    chk({nm, "_rdy"}, dec_ready_o, rdy);
    chk({nm, "_qv"}, q_valid_o, qv);
    if (qv != 4'd0) chk({nm, "_uop"}, q_uop_o, {16{tg}});
    chk({nm, "_ill"}, illegal_o, ill);
    chk({nm, "_busy"}, busy_o, busy);
    chk({nm, "_err"}, credit_err_o, err);
    chk({nm, "_cr"}, credits_o, cr);
  endtask
  task automatic chk_reset(input string nm);
    chk({nm, "_rdy"}, dec_ready_o, 1'b0);
    chk({nm, "_qv"}, q_valid_o, 4'd0);
    chk({nm, "_uop"}, q_uop_o, 128'd0);
    chk({nm, "_busy"}, busy_o, 1'b0);
    chk({nm, "_ill"}, illegal_o, 1'b0);
    chk({nm, "_err"}, credit_err_o, 1'b0);
    chk({nm, "_cr"}, credits_o, 16'h8888);
  endtask
  task automatic apply_row(input int i);
    flush_i = rows[i].fl;
    dec_valid_i = rows[i].v;
    dec_queue_i = rows[i].q;
    dec_uop_i = {16{rows[i].tag}};
    q_credit_ret_i = rows[i].ret;
    #3;
    chk_out($sformatf("row%0d", i), rows[i].rdy, rows[i].qv, rows[i].tg, rows[i].ill, rows[i].busy,
            rows[i].err, rows[i].cr);
  endtask
  task automatic apply_rows(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      apply_row(i);
      tick();
    end
  endtask
  function automatic logic [15:0] cr_with(input int q, input logic [3:0] val);
    logic [15:0] c = 16'h8888;
    c[q*4 +: 4] = val;
    return c;
  endfunction
  // Nine back-to-back uops to one queue from full credit: eight dispatch, the ninth ends at the head.
  task automatic run9(input int q, input logic [7:0] base);
    for (int i = 0; i < 9; i++) begin
      flush_i = 1'b0;
      dec_valid_i = 1'b1;
      dec_queue_i = 3'(q);
      dec_uop_i = {16{8'(base + 8'(i))}};
      q_credit_ret_i = 4'd0;
      #3;
      chk_out($sformatf("run9_q%0d_c%0d", q, i), 1'b1, (i == 0) ? 4'd0 : 4'(1 << q),
              8'(base + 8'(i) - 8'd1), 1'b0, i != 0, 1'b0, cr_with(q, (i == 0) ? 4'd8 : 4'(9 - i)));
      tick();
    end
  endtask
  task automatic pulse_reset(input string nm);
    rstn_i = 1'b0;
    #3;
    chk_reset(nm);
    tick();
    rstn_i = 1'b1;
  endtask
  int s_a, s_b, s_d, s_e;
  initial begin
    // single dispatch, credit cancel at 5, saturation, illegal queue ids
    add(0,1,0,8'hA1,0, 1,4'h0,0,    0,0,0,16'h8888);
    add(0,0,0,0,0,     1,4'h1,8'hA1,0,1,0,16'h8888);
    add(0,0,0,0,0,     1,4'h0,0,    0,0,0,16'h8887);
    add(0,1,3,8'hB1,0, 1,4'h0,0,    0,0,0,16'h8887);
    add(0,1,3,8'hB2,0, 1,4'h8,8'hB1,0,1,0,16'h8887);
    add(0,1,3,8'hB3,0, 1,4'h8,8'hB2,0,1,0,16'h7887);
    add(0,1,3,8'hB4,0, 1,4'h8,8'hB3,0,1,0,16'h6887);
    add(0,0,0,0,4'h8,  1,4'h8,8'hB4,0,1,0,16'h5887);
    add(0,0,0,0,0,     1,4'h0,0,    0,0,0,16'h5887);
    add(0,0,0,0,4'h1,  1,4'h0,0,    0,0,0,16'h5887);
    add(0,0,0,0,4'h1,  1,4'h0,0,    0,0,0,16'h5888);
    add(0,0,0,0,0,     1,4'h0,0,    0,0,1,16'h5888);
    add(0,1,5,8'hC1,0, 1,4'h0,0,    0,0,1,16'h5888);
    add(0,0,0,0,0,     1,4'h0,0,    1,0,1,16'h5888);
    add(0,0,0,0,0,     1,4'h0,0,    0,0,1,16'h5888);
    add(0,0,0,0,4'h8,  1,4'h0,0,    0,0,1,16'h5888);
    add(0,0,0,0,4'h8,  1,4'h0,0,    0,0,1,16'h6888);
    add(0,0,0,0,4'h8,  1,4'h0,0,    0,0,1,16'h7888);
    add(0,0,0,0,0,     1,4'h0,0,    0,0,1,16'h8888);
    add(0,1,4,8'hC2,0, 1,4'h0,0,    0,0,1,16'h8888);
    add(0,0,0,0,0,     1,4'h0,0,    1,0,1,16'h8888);
    add(0,1,1,8'hD1,0, 1,4'h0,0,    0,0,1,16'h8888);
    add(0,0,0,0,0,     1,4'h2,8'hD1,0,1,1,16'h8888);
    add(0,0,0,0,0,     1,4'h0,0,    0,0,1,16'h8878);
    // queue 1 exhausted: stall, fill to two, single return releases the ninth
    s_a = n;
    add(0,1,0,8'h19,0,    1,4'h0,0,    0,1,0,16'h8808);
    add(0,1,0,8'h1A,4'h2, 0,4'h0,0,    0,1,0,16'h8808);
    add(0,0,0,0,0,        0,4'h2,8'h18,0,1,0,16'h8818);
    add(0,0,0,0,0,        1,4'h1,8'h19,0,1,0,16'h8808);
    add(0,0,0,0,0,        1,4'h0,0,    0,0,0,16'h8807);
    // head-of-line: queue 2 head blocks a queue 0 entry that has credit
    s_b = n;
    add(0,1,0,8'h29,0,    1,4'h0,0,    0,1,0,16'h8088);
    add(0,0,0,0,0,        0,4'h0,0,    0,1,0,16'h8088);
    add(0,0,0,0,0,        0,4'h0,0,    0,1,0,16'h8088);
    add(0,0,0,0,4'h4,     0,4'h0,0,    0,1,0,16'h8088);
    add(0,0,0,0,0,        0,4'h4,8'h28,0,1,0,16'h8188);
    add(0,0,0,0,0,        1,4'h1,8'h29,0,1,0,16'h8088);
    add(0,0,0,0,0,        1,4'h0,0,    0,0,0,16'h8087);
    // flush with a dispatchable head at count 2; return during flush is kept
    add(0,1,2,8'h30,0,    1,4'h0,0,    0,0,0,16'h8087);
    add(0,1,2,8'h31,0,    1,4'h0,0,    0,1,0,16'h8087);
    add(0,0,0,0,4'h4,     0,4'h0,0,    0,1,0,16'h8087);
    add(1,1,0,8'h32,4'h4, 0,4'h0,0,    0,1,0,16'h8187);
    add(0,0,0,0,0,        1,4'h0,0,    0,0,0,16'h8287);
    // set the sticky error, then build a stall that reset will interrupt
    s_d = n;
    add(0,0,0,0,4'h8,     1,4'h0,0,    0,0,0,16'h8287);
    add(0,1,2,8'h40,0,    1,4'h0,0,    0,0,1,16'h8287);
    add(0,1,2,8'h41,0,    1,4'h4,8'h40,0,1,1,16'h8287);
    add(0,1,2,8'h42,0,    1,4'h4,8'h41,0,1,1,16'h8187);
    add(0,0,0,0,0,        1,4'h0,0,    0,1,1,16'h8087);
    s_e = n;
    add(0,0,0,0,0,        1,4'h0,0,    0,0,0,16'h8888);
    rstn_i = 1'b0;
    flush_i = 1'b0;
    dec_valid_i = 1'b0;
    dec_queue_i = 3'd0;
    dec_uop_i = '0;
    q_credit_ret_i = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("por");
    rstn_i = 1'b1;
    apply_rows(0, s_a);
    pulse_reset("rst_a");
    run9(1, 8'h10);
    apply_rows(s_a, s_b);
    pulse_reset("rst_b");
    run9(2, 8'h20);
    apply_rows(s_b, s_e - 1);
    apply_row(s_e - 1);
    #1;
    rstn_i = 1'b0;
    #1;
    chk_reset("mid_stall");
    tick();
    tick();
    rstn_i = 1'b1;
    apply_rows(s_e, n);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
